sik_fetch: RTL and testbench

- Stage 1 of the two-thread interleaved SIK stack pipeline.
- Owns both per-thread program counters and alternates issue between thread 0 and thread 1 every cycle.
- Reads a synchronous instruction memory and hands {thread, pc, ir, state number} to the Stage 2 decode/stack-pointer block.
- Accepts per-thread redirects (jump/call/ret/taken JumpT/JumpF), stalls (Test) and halts from downstream stages.

---
 rtl/sik_fetch_if.sv | 43 ++++
 rtl/sik_fetch.sv | 180 ++++++++++++++++++
 tb/tb_sik_fetch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sik_fetch_if.sv
// ---------------------------------------------------------------------------
// sik_fetch_if
// Bus bundle between the SIK fetch stage and its neighbours.
//   master : the fetch stage. It receives control and instruction data and
//            drives imem_addr plus the out_* decode-side fields.
//   slave  : the neighbours. Downstream control, instruction memory and the
//            decode stage.
// Signals:
//   stall[1:0], halt[1:0]    per-thread issue control
//   redirect_valid/thread/pc per-thread PC redirect
//   imem_addr                {thread, pc} to the synchronous instruction memory
//   imem_rdata               instruction word, one cycle after imem_addr
//   out_valid/thread/pc/ir/sn/pre_valid/pre   fetched instruction to decode
// ---------------------------------------------------------------------------
interface sik_fetch_if #(
   parameter int unsigned PC_W = 16,
   parameter int unsigned IR_W = 16
);
   logic [1:0]      stall;
   logic [1:0]      halt;
   logic            redirect_valid;
   logic            redirect_thread;
   logic [PC_W-1:0] redirect_pc;
   logic [PC_W:0]   imem_addr;
   logic [IR_W-1:0] imem_rdata;
   logic            out_valid;
   logic            out_thread;
   logic [PC_W-1:0] out_pc;
   logic [IR_W-1:0] out_ir;
   logic [7:0]      out_sn;
   logic            out_pre_valid;
   logic [3:0]      out_pre;

   modport master (
      input  stall, halt, redirect_valid, redirect_thread, redirect_pc, imem_rdata,
      output imem_addr, out_valid, out_thread, out_pc, out_ir, out_sn, out_pre_valid, out_pre
   );

   modport slave (
      output stall, halt, redirect_valid, redirect_thread, redirect_pc, imem_rdata,
      input  imem_addr, out_valid, out_thread, out_pc, out_ir, out_sn, out_pre_valid, out_pre
   );
endinterface

// File: rtl/sik_fetch.sv
// ---------------------------------------------------------------------------
// sik_fetch
// Stage 1 of the two-thread interleaved SIK stack pipeline. Holds both thread
// PCs and issues them on alternate cycles (slot 0 = thread 0) into a
// synchronous instruction memory. One cycle later it registers the returned
// word, with its predecoded state number, toward decode.
// Ports:
//   clk    pipeline clock
//   reset  synchronous, active-low
//   bus    sik_fetch_if.master (stall/halt/redirect in, imem bus, out_* fields)
// Optional feature (macro SIK_FETCH_PRE_FOLD_EN): a Pre word (ir[15:12]==4'hb)
// is not emitted. Instead, its nibble is attached to the next valid emit of the
// same thread through out_pre_valid/out_pre. When the macro is undefined, Pre
// flows through as an ordinary instruction and both fields are tied to 0.
// ---------------------------------------------------------------------------
module sik_fetch #(
   parameter int unsigned     PC_W   = 16,
   parameter int unsigned     IR_W   = 16,
   parameter logic [PC_W-1:0] RST_PC = 16'h0000
) (
   input logic         clk,
   input logic         reset,
   sik_fetch_if.master bus
);

   localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [7:0]      SN_NOP  = 8'hf0;
   localparam logic [IR_W-1:0] IR_NOP  = {{(IR_W-8){1'b1}}, 8'hf0};

   // State number: opcode nibble, plus the low nibble only for opcode 0
   function automatic logic [7:0] predecode(input logic [IR_W-1:0] ir);
      logic [3:0] op;
      op = ir[IR_W-1 -: 4];
      return {op, (op == 4'h0) ? ir[3:0] : 4'h0};
   endfunction

   logic            slot_r;
   logic [PC_W-1:0] pc_r [0:1];
   logic            inflight_valid_r;
   logic            inflight_thread_r;
   logic [PC_W-1:0] inflight_pc_r;

   logic            out_valid_r;
   logic            out_thread_r;
   logic [PC_W-1:0] out_pc_r;
   logic [IR_W-1:0] out_ir_r;
   logic [7:0]      out_sn_r;

   logic [PC_W-1:0] pc_sel_s;
   logic            issue_s;
   logic [PC_W:0]   imem_addr_s;
   logic            squash_s;
   logic            emit_s;
   logic            is_pre_s;

`ifdef SIK_FETCH_PRE_FOLD_EN
   logic [1:0] pre_pend_r;
   logic [3:0] pre_val_r [0:1];
   logic       out_pre_valid_r;
   logic [3:0] out_pre_r;

   assign is_pre_s          = (bus.imem_rdata[IR_W-1 -: 4] == 4'hb);
   assign bus.out_pre_valid = out_pre_valid_r;
   assign bus.out_pre       = out_pre_r;
`else
   assign is_pre_s          = 1'b0;
   assign bus.out_pre_valid = 1'b0;
   assign bus.out_pre       = 4'h0;
`endif

   // Issue side: a same-cycle redirect for the slot thread overrides its stored PC
   always_comb begin
      pc_sel_s    = pc_r[slot_r];
      issue_s     = 1'b0;
      imem_addr_s = {(PC_W+1){1'b0}};
      if (bus.redirect_valid && (bus.redirect_thread == slot_r)) begin
         pc_sel_s = bus.redirect_pc;
      end else begin
         pc_sel_s = pc_r[slot_r];
      end
      issue_s = !bus.halt[slot_r] && !bus.stall[slot_r];
      // Address is driven even for a non-issuing slot. It is held at 0 while in reset.
      if (reset) begin
         imem_addr_s = {slot_r, pc_sel_s};
      end else begin
         imem_addr_s = {(PC_W+1){1'b0}};
      end
   end

   // Emit side: drop the in-flight word if its thread is redirected or halted now
   always_comb begin
      squash_s = (bus.redirect_valid && (bus.redirect_thread == inflight_thread_r))
                 || bus.halt[inflight_thread_r];
      emit_s   = inflight_valid_r && !squash_s;
   end

   // Slot toggle, per-thread PCs and the in-flight fetch record
   always_ff @(posedge clk) begin
      if (!reset) begin
         slot_r            <= 1'b0;
         pc_r[0]           <= RST_PC;
         pc_r[1]           <= RST_PC;
         inflight_valid_r  <= 1'b0;
         inflight_thread_r <= 1'b0;
         inflight_pc_r     <= {PC_W{1'b0}};
      end else begin
         slot_r            <= ~slot_r;
         inflight_valid_r  <= issue_s;
         inflight_thread_r <= slot_r;
         inflight_pc_r     <= pc_sel_s;
         // A blocked slot still captures a redirect: redirect wins on pc, stall on issue
         if (issue_s) begin
            pc_r[slot_r] <= pc_sel_s + PC_ONE;
         end else begin
            pc_r[slot_r] <= pc_sel_s;
         end
         // A redirect for the off-slot thread lands directly in its PC
         if (bus.redirect_valid && (bus.redirect_thread != slot_r)) begin
            pc_r[bus.redirect_thread] <= bus.redirect_pc;
         end
      end
   end

   // Registered outputs toward decode. Idle and squashed slots emit the NOP encoding.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_r  <= 1'b0;
         out_thread_r <= 1'b0;
         out_pc_r     <= {PC_W{1'b0}};
         out_ir_r     <= {IR_W{1'b0}};
         out_sn_r     <= SN_NOP;
      end else begin
         out_thread_r <= inflight_thread_r;
         out_pc_r     <= inflight_pc_r;
         if (emit_s && !is_pre_s) begin
            out_valid_r <= 1'b1;
            out_ir_r    <= bus.imem_rdata;
            out_sn_r    <= predecode(bus.imem_rdata);
         end else begin
            out_valid_r <= 1'b0;
            out_ir_r    <= IR_NOP;
            out_sn_r    <= SN_NOP;
         end
      end
   end

`ifdef SIK_FETCH_PRE_FOLD_EN
   // Pre folding: latch an unsquashed Pre, then attach it to the thread's next real emit
   always_ff @(posedge clk) begin
      if (!reset) begin
         pre_pend_r      <= 2'b00;
         pre_val_r[0]    <= 4'h0;
         pre_val_r[1]    <= 4'h0;
         out_pre_valid_r <= 1'b0;
         out_pre_r       <= 4'h0;
      end else if (emit_s && is_pre_s) begin
         pre_pend_r[inflight_thread_r] <= 1'b1;
         pre_val_r[inflight_thread_r]  <= bus.imem_rdata[3:0];
         out_pre_valid_r               <= 1'b0;
         out_pre_r                     <= 4'h0;
      end else if (emit_s) begin
         pre_pend_r[inflight_thread_r] <= 1'b0;
         out_pre_valid_r               <= pre_pend_r[inflight_thread_r];
         out_pre_r                     <= pre_pend_r[inflight_thread_r]
                                          ? pre_val_r[inflight_thread_r] : 4'h0;
      end else begin
         out_pre_valid_r <= 1'b0;
         out_pre_r       <= 4'h0;
      end
   end
`endif

   assign bus.imem_addr  = imem_addr_s;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_thread = out_thread_r;
   assign bus.out_pc     = out_pc_r;
   assign bus.out_ir     = out_ir_r;
   assign bus.out_sn     = out_sn_r;

endmodule

// File: tb/tb_sik_fetch.sv
// ---------------------------------------------------------------------------
// tb_sik_fetch
// Directed stimulus for sik_fetch. Each issuing cycle pushes its expected emit
// into a scoreboard queue. A negedge monitor pops an entry on every out_valid
// and checks the NOP encoding on idle cycles.
// ---------------------------------------------------------------------------
module tb_sik_fetch;

   typedef struct packed {
      logic        t;
      logic [15:0] pc;
      logic [15:0] ir;
      logic [7:0]  sn;
      logic        pv;
      logic [3:0]  p;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic rst_q = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   exp_t mon_got;

   sik_fetch_if #(.PC_W(16), .IR_W(16)) bus ();

   sik_fetch #(.PC_W(16), .IR_W(16), .RST_PC(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a few fixed words, otherwise {0, pc[10:0], thread}
   function automatic logic [15:0] mem_word(input logic [16:0] a);
      case (a)
         17'h00000: return 16'h1005;
         17'h00001: return 16'h0000;
         17'h00002: return 16'h0001;
         17'h10000: return 16'h0004;
         17'h00200: return 16'hb00a;
         17'h00201: return 16'h5034;
         default:   return {4'h0, a[10:0], a[16]};
      endcase
   endfunction

   always @(posedge clk) begin
      bus.imem_rdata <= mem_word(bus.imem_addr);
      rst_q          <= reset;
   end

   // Monitor: pop on every valid emit; otherwise expect the NOP encoding after a non-reset edge
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         total = total + 1;
         mon_got = {bus.out_thread, bus.out_pc, bus.out_ir, bus.out_sn, bus.out_pre_valid, bus.out_pre};
         if (sb_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL emit_unexpected: got t=%0d pc=%h ir=%h sn=%h, required no emit",
                     mon_got.t, mon_got.pc, mon_got.ir, mon_got.sn);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_got !== mon_e) begin
               bad = bad + 1;
               $display("FAIL emit: got t=%0d pc=%h ir=%h sn=%h pv=%0d pre=%h, required t=%0d pc=%h ir=%h sn=%h pv=%0d pre=%h",
                        mon_got.t, mon_got.pc, mon_got.ir, mon_got.sn, mon_got.pv, mon_got.p,
                        mon_e.t, mon_e.pc, mon_e.ir, mon_e.sn, mon_e.pv, mon_e.p);
            end
         end
      end else if (rst_q === 1'b1) begin
         total = total + 1;
         if (bus.out_sn !== 8'hf0 || bus.out_ir !== 16'hfff0 || bus.out_pre_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL idle_nop: got sn=%h ir=%h pv=%0d, required sn=f0 ir=fff0 pv=0",
                     bus.out_sn, bus.out_ir, bus.out_pre_valid);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      total = total + 1;
      if (got !== req) begin
         bad = bad + 1;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic check_reset();
      chk("rst_out_valid",  {31'd0, bus.out_valid},     32'd0);
      chk("rst_out_thread", {31'd0, bus.out_thread},    32'd0);
      chk("rst_out_pc",     {16'd0, bus.out_pc},        32'd0);
      chk("rst_out_ir",     {16'd0, bus.out_ir},        32'd0);
      chk("rst_out_sn",     {24'd0, bus.out_sn},        32'h0000_00f0);
      chk("rst_out_pre",    {27'd0, bus.out_pre_valid, bus.out_pre}, 32'd0);
      chk("rst_imem_addr",  {15'd0, bus.imem_addr},     32'd0);
   endtask

   task automatic exp_emit(input logic t, input logic [15:0] pc, input logic [15:0] ir,
                           input logic [7:0] sn, input logic pv, input logic [3:0] p);
      exp_t e;
      e.t = t; e.pc = pc; e.ir = ir; e.sn = sn; e.pv = pv; e.p = p;
      sb_q.push_back(e);
   endtask

   // Apply one cycle of inputs, then advance to just after the next posedge
   task automatic cyc(input logic [1:0] st, input logic [1:0] hl, input logic rv,
                      input logic rt, input logic [15:0] rpc, input logic rs);
      bus.stall = st;
      bus.halt = hl;
      bus.redirect_valid = rv;
      bus.redirect_thread = rt;
      bus.redirect_pc = rpc;
      reset = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      bus.stall = 2'b00;
      bus.halt = 2'b00;
      bus.redirect_valid = 1'b0;
      bus.redirect_thread = 1'b0;
      bus.redirect_pc = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check_reset();

      // Release: threads alternate from thread 0 at pc 0
      exp_emit(1'b0, 16'h0000, 16'h1005, 8'h10, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0000, 16'h0004, 8'h04, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0001, 16'h0000, 8'h00, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0001, 16'h0003, 8'h03, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0002, 16'h0001, 8'h01, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0002, 16'h0005, 8'h05, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      // t0 pc3 issued, then redirected to 0x0123 while in flight (squashed)
      cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0003, 16'h0007, 8'h07, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b1, 1'b0, 16'h0123, 1'b1);
      exp_emit(1'b0, 16'h0123, 16'h0246, 8'h06, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0004, 16'h0009, 8'h09, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      // Thread 1 stalled for 6 cycles
      exp_emit(1'b0, 16'h0124, 16'h0248, 8'h08, 1'b0, 4'h0); cyc(2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      cyc(2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0125, 16'h024a, 8'h0a, 1'b0, 4'h0); cyc(2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      cyc(2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0126, 16'h024c, 8'h0c, 1'b0, 4'h0); cyc(2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      cyc(2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0127, 16'h024e, 8'h0e, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0005, 16'h000b, 8'h0b, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      // In-slot redirect to 0xffff, then wrap to 0
      exp_emit(1'b0, 16'hffff, 16'h0ffe, 8'h0e, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b1, 1'b0, 16'hffff, 1'b1);
      exp_emit(1'b1, 16'h0006, 16'h000d, 8'h0d, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0000, 16'h1005, 8'h10, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0007, 16'h000f, 8'h0f, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      // Redirect and stall together on t0: pc taken, no issue
      cyc(2'b01, 2'b00, 1'b1, 1'b0, 16'h0040, 1'b1);
      exp_emit(1'b1, 16'h0008, 16'h0011, 8'h01, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      // t0 fetch of 0x0040 squashed by halt rising next cycle
      cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0009, 16'h0013, 8'h03, 1'b0, 4'h0); cyc(2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1);
      cyc(2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h000a, 16'h0015, 8'h05, 1'b0, 4'h0); cyc(2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1);
      cyc(2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1);
      // t1 pc 0x000b in flight is squashed by a one-cycle reset
      cyc(2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1);
      cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
      check_reset();

      exp_emit(1'b0, 16'h0000, 16'h1005, 8'h10, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b1, 16'h0000, 16'h0004, 8'h04, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      // Pre (0xb00a) followed by 0x5034 on thread 0
`ifdef SIK_FETCH_PRE_FOLD_EN
      cyc(2'b00, 2'b00, 1'b1, 1'b0, 16'h0200, 1'b1);
      exp_emit(1'b1, 16'h0001, 16'h0003, 8'h03, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0201, 16'h5034, 8'h50, 1'b1, 4'ha); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
`else
      exp_emit(1'b0, 16'h0200, 16'hb00a, 8'hb0, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b1, 1'b0, 16'h0200, 1'b1);
      exp_emit(1'b1, 16'h0001, 16'h0003, 8'h03, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0201, 16'h5034, 8'h50, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
`endif
      exp_emit(1'b1, 16'h0002, 16'h0005, 8'h05, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      exp_emit(1'b0, 16'h0202, 16'h0404, 8'h04, 1'b0, 4'h0); cyc(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      // Drain with both threads stalled
      for (int i = 0; i < 4; i++) begin
         cyc(2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1);
      end
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
